audio_sample_sequencer: RTL and testbench

- Parametrised playback address generator for the on-chip audio sample ROM.
- Holds off until the codec init sequence finishes, then plays a sample window [start_addr, end_addr] when commanded.
- Advances Add at a programmable divided rate, gated by the codec's data_over request.
- Over the earlier fixed 100000-word generator it adds: runtime window selection, loop or one-shot mode, pause, stop, restart, and busy/done/step status.

---
 rtl/audio_sample_sequencer.sv | 146 ++++++++++++++
 tb/tb_audio_sample_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_sequencer.sv
// Playback address generator for the audio sample ROM: waits for codec init, then walks a
// latched [start, end] window at one step per DIV-clock slot, gated by data_over.
module audio_sample_sequencer #(
   parameter int unsigned ADDR_W = 17,
   parameter int unsigned DIV    = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              INIT_FINISH,
   input  logic              data_over,
   input  logic              play,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   output logic              INIT,
   output logic [ADDR_W-1:0] Add,
   output logic              busy,
   output logic              done,
   output logic              step
);

   typedef enum logic [1:0] {StWaitInit, StIdle, StPlay, StPause} state_e;

   localparam logic [CNT_W-1:0] DivMax = CNT_W'(DIV - 1);

   state_e              r_state, w_state_d;
   logic [ADDR_W-1:0]   r_add, w_add_d;
   logic [ADDR_W-1:0]   r_start, w_start_d;
   logic [ADDR_W-1:0]   r_end, w_end_d;
   logic [CNT_W-1:0]    r_div, w_div_d;
   logic                r_loop, w_loop_d;
   logic                r_init;
   logic                r_step, w_step_d;
   logic                r_done, w_done_d;
   logic                w_busy;
   logic                w_restart;
   logic                w_slot;

   // Stop in IDLE is a no-op, so there a coincident play still starts playback.
   assign w_restart = play && ((r_state == StIdle) || (w_busy && !stop));
   assign w_slot    = (r_div == DivMax);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= StWaitInit;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_add_d   = r_add;
      w_div_d   = r_div;
      w_start_d = r_start;
      w_end_d   = r_end;
      w_loop_d  = r_loop;
      w_step_d  = 1'b0;
      w_done_d  = 1'b0;
      if (w_restart) begin
         w_state_d = StPlay;
         w_add_d   = start_addr;
         w_div_d   = '0;
         w_start_d = start_addr;
         w_end_d   = (start_addr > end_addr) ? start_addr : end_addr;
         w_loop_d  = loop_en;
      end else begin
         unique case (r_state)
            StWaitInit: begin
               if (INIT_FINISH) w_state_d = StIdle;
            end
            StIdle: begin
            end
            StPlay: begin
               if (stop) begin
                  w_state_d = StIdle;
                  w_add_d   = r_start;
                  w_div_d   = '0;
               end else if (pause) begin
                  w_state_d = StPause;
               end else begin
                  // Divider free-runs; a slot without data_over is simply lost.
                  w_div_d = w_slot ? '0 : r_div + 1'b1;
                  if (w_slot && data_over) begin
                     w_step_d = 1'b1;
                     if (r_add != r_end) begin
                        w_add_d = r_add + 1'b1;
                     end else if (r_loop) begin
                        w_add_d = r_start;
                     end else begin
                        w_done_d  = 1'b1;
                        w_state_d = StIdle;
                     end
                  end
               end
            end
            StPause: begin
               if (stop) begin
                  w_state_d = StIdle;
                  w_add_d   = r_start;
                  w_div_d   = '0;
               end else if (!pause) begin
                  w_state_d = StPlay;
               end
            end
            default: w_state_d = StWaitInit;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_add   <= '0;
         r_div   <= '0;
         r_start <= '0;
         r_end   <= '0;
         r_loop  <= 1'b0;
         r_init  <= 1'b0;
         r_step  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_add   <= w_add_d;
         r_div   <= w_div_d;
         r_start <= w_start_d;
         r_end   <= w_end_d;
         r_loop  <= w_loop_d;
         r_init  <= 1'b1;
         r_step  <= w_step_d;
         r_done  <= w_done_d;
      end
   end

   always_comb begin
      w_busy = (r_state == StPlay) || (r_state == StPause);
   end

   assign busy = w_busy;
   assign INIT = r_init;
   assign Add  = r_add;
   assign step = r_step;
   assign done = r_done;

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Directed bench for audio_sample_sequencer with DIV=4: init gating, one-shot, loop,
// lost slots, pause, degenerate window, stop/play priority and async reset.
module tb_audio_sample_sequencer;

   localparam int unsigned ADDR_W = 17;

   logic              Clk = 1'b0;
   logic              Reset;
   logic              INIT_FINISH, data_over, play, stop, pause, loop_en;
   logic [ADDR_W-1:0] start_addr, end_addr;
   logic              INIT, busy, done, step;
   logic [ADDR_W-1:0] Add;

   int n_checks = 0;
   int n_errors = 0;

   audio_sample_sequencer #(
      .ADDR_W (ADDR_W),
      .DIV    (4),
      .CNT_W  (16)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .INIT_FINISH (INIT_FINISH),
      .data_over   (data_over),
      .play        (play),
      .stop        (stop),
      .pause       (pause),
      .loop_en     (loop_en),
      .start_addr  (start_addr),
      .end_addr    (end_addr),
      .INIT        (INIT),
      .Add         (Add),
      .busy        (busy),
      .done        (done),
      .step        (step)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One DIV=4 slot starting right after a divider reset/wrap: three quiet edges, then the slot.
   task automatic slot(input string tag, input logic exp_step, input logic [31:0] exp_add,
                       input logic exp_done, input logic exp_busy);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk({tag, "_pre_step"}, 32'(step), 32'd0);
      end
      tick();
      chk({tag, "_step"}, 32'(step), 32'(exp_step));
      chk({tag, "_add"}, 32'(Add), exp_add);
      chk({tag, "_done"}, 32'(done), 32'(exp_done));
      chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset = 1'b1; INIT_FINISH = 1'b0; data_over = 1'b0; play = 1'b0; stop = 1'b0;
      pause = 1'b0; loop_en = 1'b0; start_addr = '0; end_addr = '0;
      #2;
      chk("rst_init", 32'(INIT), 32'd0);
      chk("rst_add", 32'(Add), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_step", 32'(step), 32'd0);

      // WAIT_INIT: play ignored while INIT_FINISH low
      #1; Reset = 1'b0; play = 1'b1; start_addr = 17'd10; end_addr = 17'd12;
      tick();
      chk("init_first_edge", 32'(INIT), 32'd1);
      chk("wait_play_busy", 32'(busy), 32'd0);
      chk("wait_play_add", 32'(Add), 32'd0);
      play = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("wait_busy", 32'(busy), 32'd0);
      end
      // play on the same edge as INIT_FINISH is still in WAIT_INIT
      INIT_FINISH = 1'b1; play = 1'b1;
      tick();
      chk("finish_edge_busy", 32'(busy), 32'd0);
      play = 1'b0; INIT_FINISH = 1'b0;
      tick();

      // One-shot window 10..12
      data_over = 1'b1; play = 1'b1;
      tick();
      play = 1'b0;
      chk("os_start_add", 32'(Add), 32'd10);
      chk("os_start_busy", 32'(busy), 32'd1);
      slot("os1", 1'b1, 32'd11, 1'b0, 1'b1);
      slot("os2", 1'b1, 32'd12, 1'b0, 1'b1);
      slot("os3", 1'b1, 32'd12, 1'b1, 1'b0);
      tick();
      chk("os_after_done", 32'(done), 32'd0);
      chk("os_after_step", 32'(step), 32'd0);
      chk("os_after_add", 32'(Add), 32'd12);

      // Loop window 10..12
      loop_en = 1'b1; play = 1'b1;
      tick();
      play = 1'b0;
      chk("lp_start_add", 32'(Add), 32'd10);
      slot("lp1", 1'b1, 32'd11, 1'b0, 1'b1);
      slot("lp2", 1'b1, 32'd12, 1'b0, 1'b1);
      slot("lp3", 1'b1, 32'd10, 1'b0, 1'b1);
      slot("lp4", 1'b1, 32'd11, 1'b0, 1'b1);

      // Lost slots with data_over low
      data_over = 1'b0;
      slot("lost1", 1'b0, 32'd11, 1'b0, 1'b1);
      slot("lost2", 1'b0, 32'd11, 1'b0, 1'b1);
      data_over = 1'b1;
      slot("resume", 1'b1, 32'd12, 1'b0, 1'b1);

      // Pause mid-slot at divider=2 for 7 edges, then 1 release edge + 2 edges to the slot
      tick(); tick();
      pause = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("pause_busy", 32'(busy), 32'd1);
         chk("pause_add", 32'(Add), 32'd12);
         chk("pause_step", 32'(step), 32'd0);
      end
      pause = 1'b0;
      tick();
      chk("unpause_e1_step", 32'(step), 32'd0);
      tick();
      chk("unpause_e2_step", 32'(step), 32'd0);
      tick();
      chk("unpause_slot_step", 32'(step), 32'd1);
      chk("unpause_slot_add", 32'(Add), 32'd10);

      // Restart from PLAY with start > end: single-sample window
      loop_en = 1'b0; start_addr = 17'd50; end_addr = 17'd40; play = 1'b1;
      tick();
      play = 1'b0;
      chk("ss_add", 32'(Add), 32'd50);
      chk("ss_done_restart", 32'(done), 32'd0);
      chk("ss_busy", 32'(busy), 32'd1);
      slot("ss1", 1'b1, 32'd50, 1'b1, 1'b0);

      // stop beats play while playing
      start_addr = 17'd20; end_addr = 17'd30; play = 1'b1;
      tick();
      play = 1'b0;
      slot("sp1", 1'b1, 32'd21, 1'b0, 1'b1);
      stop = 1'b1; play = 1'b1; start_addr = 17'd70; end_addr = 17'd80;
      tick();
      chk("sp_busy", 32'(busy), 32'd0);
      chk("sp_add", 32'(Add), 32'd20);
      chk("sp_done", 32'(done), 32'd0);
      play = 1'b0;
      tick();
      chk("idle_stop_add", 32'(Add), 32'd20);
      chk("idle_stop_busy", 32'(busy), 32'd0);
      stop = 1'b0; start_addr = 17'd5; end_addr = 17'd9; play = 1'b1;
      tick();
      play = 1'b0;
      chk("replay_add", 32'(Add), 32'd5);
      chk("replay_busy", 32'(busy), 32'd1);

      // Async reset between edges
      tick(); tick();
      #2; Reset = 1'b1;
      #1;
      chk("async_add", 32'(Add), 32'd0);
      chk("async_init", 32'(INIT), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      Reset = 1'b0; play = 1'b1;
      tick();
      chk("post_rst_init", 32'(INIT), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_add", 32'(Add), 32'd0);
      INIT_FINISH = 1'b1;
      tick();
      chk("post_rst_finish_busy", 32'(busy), 32'd0);
      tick();
      chk("post_rst_play_busy", 32'(busy), 32'd1);
      chk("post_rst_play_add", 32'(Add), 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
